wave_sweep_ctrl: RTL and testbench
==================================

WAVE_SWEEP_CTRL -- requirements
Module: wave_sweep_ctrl

Interface
REQ-001 SHALL have no parameters; all widths below are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 cfg_valid  input  1  host config write request.
REQ-005 cfg_ready  output  1  controller accepts config write; a write transfers when cfg_valid=1 and cfg_ready=1 at a clk edge.
REQ-006 cfg_addr  input  4  register select (see REQ-012).
REQ-007 cfg_data  input  16  write data.
REQ-008 start  input  1  begin sweep; sampled only in IDLE.
REQ-009 abort  input  1  terminate sweep.
REQ-010 amps, offsets, phasewords  output  32 each  registered datapath drive; [31:16] = channel 1, [15:0] = channel 0.
REQ-011 busy  output  1, done  output  1  status flags (see Function).

Function
REQ-012 Shadow registers, 16 bit each, by cfg_addr: 0 amp0, 1 amp1, 2 off0, 3 off1, 4 pwstart0, 5 pwstart1, 6 step0, 7 step1, 8 nsteps (unsigned), 9 dwell (unsigned); addresses 10-15 accepted and discarded.
REQ-013 A transferred write updates its shadow register at that edge; shadow registers never drive the outputs directly.
REQ-014 States: IDLE, LOAD, DWELL, STEP, DONE; busy=1 in every state except IDLE; cfg_ready=1 only in IDLE.
REQ-015 IDLE: start=1 and abort=0 -> LOAD; otherwise remain in IDLE.
REQ-016 LOAD (1 cycle): at exit edge load amps={amp1,amp0}, offsets={off1,off0}, phasewords={pwstart1,pwstart0}; clear step counter; go to DONE if nsteps=0, else to DWELL.
REQ-017 DWELL: counts max(dwell,1) cycles (dwell=0 treated as 1), then STEP.
REQ-018 STEP (1 cycle): at exit edge phasewords[15:0]+=step0 and phasewords[31:16]+=step1, each modulo 2^16 (wraps, no saturation; step is two's complement); step counter increments; go to DONE if counter reaches nsteps, else to DWELL.
REQ-019 Step period SHALL be max(dwell,1)+1 cycles; exactly nsteps increments occur per sweep.
REQ-020 DONE (1 cycle): done=1 for exactly this cycle, then IDLE; done=0 in all other states.
REQ-021 Outputs hold their last value in every state except at LOAD/STEP exit edges, including after DONE and after abort.
REQ-022 abort=1 in LOAD, DWELL, STEP or DONE -> IDLE at next edge, no output update on that edge, no done pulse.
REQ-023 start while busy is ignored; abort and start together in IDLE: start ignored.
REQ-024 A write transferred on the same edge start is accepted is visible to the following LOAD.
REQ-025 Shadow register values persist across sweeps; amps and offsets change only at LOAD.

Reset
REQ-026 reset=0 SHALL immediately clear all shadow registers, amps, offsets, phasewords, step and dwell counters to 0 and force IDLE, irrespective of clk.
REQ-027 During and after reset: busy=0, done=0, cfg_ready=1; reset asserted mid-sweep aborts the sweep with no done pulse.

Verification
REQ-028 Write amp0=0x1000, amp1=0x2000, nsteps=0, pulse start -> phasewords={pwstart1,pwstart0} and amps=0x20001000 after the LOAD exit edge; done=1 on the following cycle; busy=1 for exactly 2 cycles.
REQ-029 pwstart0=0x0100, step0=0x0010, nsteps=3, dwell=2 -> phasewords[15:0] sequence 0x0100, 0x0110, 0x0120, 0x0130, 3 cycles between changes; done pulse 1 cycle after the last change; value 0x0130 held afterwards.
REQ-030 pwstart1=0xFFF0, step1=0x0020, nsteps=1 -> phasewords[31:16]=0x0010 (wrap); step1=0xFFFF from 0x0000 -> 0xFFFF.
REQ-031 Abort asserted in the 2nd DWELL of a 5-step sweep -> IDLE at the next edge, phasewords frozen at the step-1 value, done never asserted, cfg_ready=1 at that same edge.
REQ-032 cfg_valid held high during a sweep -> no transfer while busy; the write lands on the first IDLE cycle; start pulses during busy have no effect.
REQ-033 reset=0 asynchronously mid-DWELL -> all outputs 0, busy=0 before the next clk edge; dwell=0 sweep runs at a 2-cycle step period.

Source files
------------

// File: rtl/wave_sweep_ctrl.sv
// Two-channel phase sweep controller: host-written shadow registers are loaded
// into the datapath at sweep start, then phasewords step every dwell period.
module wave_sweep_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [3:0]  cfg_addr,
  input  logic [15:0] cfg_data,
  input  logic        start,
  input  logic        abort,
  output logic [31:0] amps,
  output logic [31:0] offsets,
  output logic [31:0] phasewords,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DWELL,
    S_STEP,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [15:0] amp0, amp1, off0, off1, pw0, pw1, step0, step1, nsteps, dwell;
  logic [15:0] step_cnt, dwell_cnt;
  logic        dwell_last, step_last;

  // dwell=0 behaves as dwell=1: the first DWELL cycle is always the last
  always_comb begin
    dwell_last = (dwell == 16'd0) ? 1'b1 : (dwell_cnt >= (dwell - 16'd1));
    step_last  = ((step_cnt + 16'd1) == nsteps);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start && !abort) state_nxt = S_LOAD;
      S_LOAD:  if (abort)                state_nxt = S_IDLE;
               else if (nsteps == 16'd0) state_nxt = S_DONE;
               else                      state_nxt = S_DWELL;
      S_DWELL: if (abort)           state_nxt = S_IDLE;
               else if (dwell_last) state_nxt = S_STEP;
      S_STEP:  if (abort)          state_nxt = S_IDLE;
               else if (step_last) state_nxt = S_DONE;
               else                state_nxt = S_DWELL;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    cfg_ready = (state == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      amp0       <= '0;
      amp1       <= '0;
      off0       <= '0;
      off1       <= '0;
      pw0        <= '0;
      pw1        <= '0;
      step0      <= '0;
      step1      <= '0;
      nsteps     <= '0;
      dwell      <= '0;
      amps       <= '0;
      offsets    <= '0;
      phasewords <= '0;
      step_cnt   <= '0;
      dwell_cnt  <= '0;
    end else begin
      if (cfg_valid && cfg_ready) begin
        case (cfg_addr)
          4'd0:    amp0   <= cfg_data;
          4'd1:    amp1   <= cfg_data;
          4'd2:    off0   <= cfg_data;
          4'd3:    off1   <= cfg_data;
          4'd4:    pw0    <= cfg_data;
          4'd5:    pw1    <= cfg_data;
          4'd6:    step0  <= cfg_data;
          4'd7:    step1  <= cfg_data;
          4'd8:    nsteps <= cfg_data;
          4'd9:    dwell  <= cfg_data;
          default: ;
        endcase
      end
      // abort takes priority: the edge leaving for IDLE never updates outputs
      if (!abort) begin
        case (state)
          S_LOAD: begin
            amps       <= {amp1, amp0};
            offsets    <= {off1, off0};
            phasewords <= {pw1, pw0};
            step_cnt   <= '0;
            dwell_cnt  <= '0;
          end
          S_DWELL: begin
            if (!dwell_last) dwell_cnt <= dwell_cnt + 16'd1;
          end
          S_STEP: begin
            phasewords <= {phasewords[31:16] + step1, phasewords[15:0] + step0};
            step_cnt   <= step_cnt + 16'd1;
            dwell_cnt  <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wave_sweep_ctrl.sv
// Scoreboard bench for wave_sweep_ctrl: stimulus queues expected output events
// and per-cycle status snapshots; a negedge monitor pops and compares them.
module tb_wave_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        start;
  logic        abort;
  logic [31:0] amps, offsets, phasewords;
  logic        busy, done;

  wave_sweep_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .start      (start),
    .abort      (abort),
    .amps       (amps),
    .offsets    (offsets),
    .phasewords (phasewords),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] a, o, p;
    logic        d, b, r;
  } rec_t;

  rec_t evq[$];
  rec_t stq[$];

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   finished = 1'b0;
  logic [95:0] prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // An output event is any change of the datapath outputs or a done pulse
  always @(negedge clk) begin
    logic [95:0] cur;
    rec_t e;
    cur = {amps, offsets, phasewords};
    if (cur != prev || done) begin
      n_checks++;
      if (evq.size() == 0) begin
        n_fail++;
        $display("FAIL event: unexpected at cycle %0d amps=%h off=%h pw=%h done=%b",
                 cyc, amps, offsets, phasewords, done);
      end else begin
        e = evq.pop_front();
        if (e.cyc != cyc || amps !== e.a || offsets !== e.o || phasewords !== e.p || done !== e.d) begin
          n_fail++;
          $display("FAIL event: got cyc=%0d amps=%h off=%h pw=%h done=%b, want cyc=%0d amps=%h off=%h pw=%h done=%b",
                   cyc, amps, offsets, phasewords, done, e.cyc, e.a, e.o, e.p, e.d);
        end
      end
    end
    prev = cur;
    while (stq.size() > 0 && stq[0].cyc <= cyc) begin
      e = stq.pop_front();
      n_checks++;
      if (e.cyc != cyc || amps !== e.a || offsets !== e.o || phasewords !== e.p ||
          busy !== e.b || done !== e.d || cfg_ready !== e.r) begin
        n_fail++;
        $display("FAIL snapshot@%0d (at %0d): got amps=%h off=%h pw=%h busy=%b done=%b rdy=%b, want amps=%h off=%h pw=%h busy=%b done=%b rdy=%b",
                 e.cyc, cyc, amps, offsets, phasewords, busy, done, cfg_ready,
                 e.a, e.o, e.p, e.b, e.d, e.r);
      end
    end
    if (finished) begin
      n_checks++;
      if (evq.size() != 0 || stq.size() != 0) begin
        n_fail++;
        $display("FAIL drain: got %0d events and %0d snapshots pending, want 0 and 0",
                 evq.size(), stq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic exp_ev(input int c, input logic [31:0] a, input logic [31:0] o,
                        input logic [31:0] p, input logic d);
    rec_t r;
    r.cyc = c; r.a = a; r.o = o; r.p = p; r.d = d; r.b = 1'b0; r.r = 1'b0;
    evq.push_back(r);
  endtask

  task automatic exp_st(input int c, input logic [31:0] a, input logic [31:0] o,
                        input logic [31:0] p, input logic b, input logic d, input logic r);
    rec_t s;
    s.cyc = c; s.a = a; s.o = o; s.p = p; s.b = b; s.d = d; s.r = r;
    stq.push_back(s);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_data  = d;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  localparam logic [31:0] A1 = 32'h2000_1000;
  localparam logic [31:0] A2 = 32'h2000_7777;
  localparam logic [31:0] OF = 32'h0004_0003;

  initial begin
    int c0;
    reset = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
    start = 1'b0; abort = 1'b0;

    exp_st(1, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    exp_st(3, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    tick(2);

    // nsteps=0: LOAD then DONE, busy for two cycles
    wr(4'd0, 16'h1000); wr(4'd1, 16'h2000); wr(4'd2, 16'h0003); wr(4'd3, 16'h0004);
    wr(4'd4, 16'h0055); wr(4'd5, 16'h00AA); wr(4'd8, 16'd0);
    c0 = cyc;
    exp_st(c0 + 1, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    exp_ev(c0 + 2, A1, OF, 32'h00AA_0055, 1'b1);
    exp_st(c0 + 2, A1, OF, 32'h00AA_0055, 1'b1, 1'b1, 1'b0);
    exp_st(c0 + 3, A1, OF, 32'h00AA_0055, 1'b0, 1'b0, 1'b1);
    pulse_start(); tick(4);

    // 3 steps, dwell=2, channel 1 wraps 0xFFF0 -> 0x0010
    wr(4'd4, 16'h0100); wr(4'd5, 16'hFFF0); wr(4'd6, 16'h0010); wr(4'd7, 16'h0020);
    wr(4'd8, 16'd3); wr(4'd9, 16'd2);
    c0 = cyc;
    exp_ev(c0 + 2,  A1, OF, 32'hFFF0_0100, 1'b0);
    exp_st(c0 + 3,  A1, OF, 32'hFFF0_0100, 1'b1, 1'b0, 1'b0);
    exp_ev(c0 + 5,  A1, OF, 32'h0010_0110, 1'b0);
    exp_ev(c0 + 8,  A1, OF, 32'h0030_0120, 1'b0);
    exp_ev(c0 + 11, A1, OF, 32'h0050_0130, 1'b1);
    exp_st(c0 + 12, A1, OF, 32'h0050_0130, 1'b0, 1'b0, 1'b1);
    pulse_start(); tick(13);

    // dwell=0 gives a 2-cycle step; step1=0xFFFF from 0 decrements
    wr(4'd5, 16'h0000); wr(4'd7, 16'hFFFF); wr(4'd9, 16'd0);
    c0 = cyc;
    exp_ev(c0 + 2, A1, OF, 32'h0000_0100, 1'b0);
    exp_ev(c0 + 4, A1, OF, 32'hFFFF_0110, 1'b0);
    exp_ev(c0 + 6, A1, OF, 32'hFFFE_0120, 1'b0);
    exp_ev(c0 + 8, A1, OF, 32'hFFFD_0130, 1'b1);
    pulse_start(); tick(10);

    // cfg_valid held and start pulsed while busy; nsteps=0 write lands in IDLE
    wr(4'd8, 16'd2); wr(4'd9, 16'd3);
    c0 = cyc;
    exp_ev(c0 + 2,  A1, OF, 32'h0000_0100, 1'b0);
    exp_ev(c0 + 6,  A1, OF, 32'hFFFF_0110, 1'b0);
    exp_ev(c0 + 10, A1, OF, 32'hFFFE_0120, 1'b1);
    exp_st(c0 + 10, A1, OF, 32'hFFFE_0120, 1'b1, 1'b1, 1'b0);
    exp_st(c0 + 11, A1, OF, 32'hFFFE_0120, 1'b0, 1'b0, 1'b1);
    pulse_start();
    cfg_valid = 1'b1; cfg_addr = 4'd8; cfg_data = 16'd0;
    tick(3);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(7);
    cfg_valid = 1'b0;

    // amp0 update plus the held nsteps=0 write both visible at next LOAD
    wr(4'd0, 16'h7777);
    c0 = cyc;
    exp_ev(c0 + 2, A2, OF, 32'h0000_0100, 1'b1);
    pulse_start(); tick(4);

    // abort in the 2nd DWELL of a 5-step sweep
    wr(4'd4, 16'h0200); wr(4'd8, 16'd5); wr(4'd9, 16'd2);
    c0 = cyc;
    exp_ev(c0 + 2, A2, OF, 32'h0000_0200, 1'b0);
    exp_ev(c0 + 5, A2, OF, 32'hFFFF_0210, 1'b0);
    exp_st(c0 + 6, A2, OF, 32'hFFFF_0210, 1'b0, 1'b0, 1'b1);
    exp_st(c0 + 10, A2, OF, 32'hFFFF_0210, 1'b0, 1'b0, 1'b1);
    pulse_start(); tick(4);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(5);

    // start with abort in IDLE is ignored
    c0 = cyc;
    exp_st(c0 + 1, A2, OF, 32'hFFFF_0210, 1'b0, 1'b0, 1'b1);
    exp_st(c0 + 2, A2, OF, 32'hFFFF_0210, 1'b0, 1'b0, 1'b1);
    start = 1'b1; abort = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    tick(3);

    // asynchronous reset mid-DWELL
    wr(4'd8, 16'd3); wr(4'd9, 16'd4);
    c0 = cyc;
    exp_ev(c0 + 2, A2, OF, 32'h0000_0200, 1'b0);
    exp_ev(c0 + 3, '0, '0, '0, 1'b0);
    exp_st(c0 + 3, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    exp_st(c0 + 4, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    pulse_start(); tick(1);
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick(2);

    // after reset dwell is 0: 2-cycle step period
    wr(4'd4, 16'h0001); wr(4'd6, 16'h0001); wr(4'd8, 16'd2);
    c0 = cyc;
    exp_ev(c0 + 2, '0, '0, 32'h0000_0001, 1'b0);
    exp_st(c0 + 3, '0, '0, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    exp_ev(c0 + 4, '0, '0, 32'h0000_0002, 1'b0);
    exp_ev(c0 + 6, '0, '0, 32'h0000_0003, 1'b1);
    exp_st(c0 + 7, '0, '0, 32'h0000_0003, 1'b0, 1'b0, 1'b1);
    pulse_start(); tick(8);

    finished = 1'b1;
  end

endmodule
